// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the in-order pipeline
// writeback (source 0, priority) and a multi-cycle unit (source 1, anti-starvation boost).
module regfile_wb_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [4:0]  s0_rd,
    input  logic [31:0] s0_data,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [4:0]  s1_rd,
    input  logic [31:0] s1_data,
    output logic        we3,
    output logic [4:0]  a3,
    output logic [31:0] wd3,
    output logic        grant_src,
    output logic        boost
);

    typedef enum logic {NORMAL, BOOST} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_reg, state_next;
    logic [3:0] wait_cnt_reg, wait_cnt_next;
    logic       s0_xfer, s1_xfer;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg    <= NORMAL;
            wait_cnt_reg <= 4'd0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
        end
    end

    always_comb begin
        s0_ready      = 1'b0;
        s1_ready      = 1'b0;
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;

        // Grants depend only on the valids and state, never on rd/data.
        if (state_reg == BOOST) begin
            s1_ready = s1_valid;
            s0_ready = s0_valid && !s1_valid;
        end else begin
            s0_ready = s0_valid;
            s1_ready = s1_valid && !s0_valid;
        end

        if (!s1_valid || s1_ready) begin
            wait_cnt_next = 4'd0;
        end else if (wait_cnt_reg < LIMIT) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end

        if (state_reg == NORMAL) begin
            if (s1_valid && !s1_ready && (wait_cnt_next == LIMIT)) begin
                state_next = BOOST;
            end
        end else if (!s1_valid || s1_ready) begin
            state_next = NORMAL;
        end
    end

    assign s0_xfer = s0_valid && s0_ready;
    assign s1_xfer = s1_valid && s1_ready;
    assign boost   = (state_reg == BOOST);

    // x0 transfers still complete and update a3/wd3, but never raise we3.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            we3       <= 1'b0;
            a3        <= 5'd0;
            wd3       <= 32'd0;
            grant_src <= 1'b0;
        end else if (s0_xfer) begin
            we3       <= (s0_rd != 5'd0);
            a3        <= s0_rd;
            wd3       <= s0_data;
            grant_src <= 1'b0;
        end else if (s1_xfer) begin
            we3       <= (s1_rd != 5'd0);
            a3        <= s1_rd;
            wd3       <= s1_data;
            grant_src <= 1'b1;
        end else begin
            we3 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: vectors push expected readies/outputs into a
// queue and a negedge monitor pops and compares them against the DUT.
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        resetn;
    logic        s0_valid, s1_valid;
    logic        s0_ready, s1_ready;
    logic [4:0]  s0_rd, s1_rd;
    logic [31:0] s0_data, s1_data;
    logic        we3;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        grant_src;
    logic        boost;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        r0;
        logic        r1;
        logic        we;
        logic [4:0]  a;
        logic [31:0] wd;
        logic        gs;
        logic        b;
    } exp_t;

    exp_t exp_q[$];
    logic [31:0] rf [32];

    regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .resetn(resetn),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rd(s0_rd), .s0_data(s0_data),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rd(s1_rd), .s1_data(s1_data),
        .we3(we3), .a3(a3), .wd3(wd3), .grant_src(grant_src), .boost(boost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: writes whatever the port presents, so x0 stays 0 only if we3 does.
    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    end
    always @(posedge clk) begin
        if (we3) rf[a3] <= wd3;
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec++;
            if ({s0_ready, s1_ready, we3, a3, wd3, grant_src, boost} !==
                {e.r0, e.r1, e.we, e.a, e.wd, e.gs, e.b}) begin
                n_miss++;
                $display("FAIL vec%0d: got r0=%b r1=%b we3=%b a3=%0d wd3=%h gs=%b boost=%b, want r0=%b r1=%b we3=%b a3=%0d wd3=%h gs=%b boost=%b",
                         n_vec, s0_ready, s1_ready, we3, a3, wd3, grant_src, boost,
                         e.r0, e.r1, e.we, e.a, e.wd, e.gs, e.b);
            end else begin
                $display("vec%0d ok: r0=%b r1=%b we3=%b a3=%0d wd3=%h gs=%b boost=%b",
                         n_vec, s0_ready, s1_ready, we3, a3, wd3, grant_src, boost);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end else begin
            $display("%s ok: %h", name, act);
        end
    endtask

    // Drive one cycle of inputs; expectations are readies this cycle and outputs already registered.
    task automatic apply(input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                         input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                         input logic er0, input logic er1, input logic ewe,
                         input logic [4:0] ea, input logic [31:0] ewd,
                         input logic egs, input logic eb);
        exp_t e;
        @(posedge clk);
        #1;
        s0_valid = v0; s0_rd = rd0; s0_data = d0;
        s1_valid = v1; s1_rd = rd1; s1_data = d1;
        e.r0 = er0; e.r1 = er1; e.we = ewe; e.a = ea; e.wd = ewd; e.gs = egs; e.b = eb;
        exp_q.push_back(e);
    endtask

    initial begin
        resetn = 1'b0;
        s0_valid = 1'b0; s0_rd = 5'd0; s0_data = 32'd0;
        s1_valid = 1'b0; s1_rd = 5'd0; s1_data = 32'd0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;

        // Write x5, then assert reset mid-cycle while we3 is high.
        @(posedge clk); #1;
        s0_valid = 1'b1; s0_rd = 5'd5; s0_data = 32'h1234_5678;
        @(posedge clk); #1;
        s0_valid = 1'b0; s0_rd = 5'd0; s0_data = 32'd0;
        chk("post_reset_we3", {31'd0, we3}, 32'd1);
        chk("post_reset_a3", {27'd0, a3}, 32'd5);
        chk("post_reset_wd3", wd3, 32'h1234_5678);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_we3", {31'd0, we3}, 32'd0);
        chk("async_rst_a3", {27'd0, a3}, 32'd0);
        chk("async_rst_wd3", wd3, 32'd0);
        chk("async_rst_boost", {31'd0, boost}, 32'd0);
        @(posedge clk); #1 resetn = 1'b1;

        //     s0v rd  data           s1v rd  data           r0 r1 we a3  wd3            gs b
        // Solo source 1, then x0 write from source 0
        apply(0, 0,  32'h0,         1, 31, 32'hDEADBEEF,  0, 1, 0, 0,  32'h0,         0, 0);
        apply(0, 0,  32'h0,         0, 0,  32'h0,         0, 0, 1, 31, 32'hDEADBEEF,  1, 0);
        apply(1, 0,  32'hFFFFFFFF,  0, 0,  32'h0,         1, 0, 0, 31, 32'hDEADBEEF,  1, 0);
        apply(0, 0,  32'h0,         0, 0,  32'h0,         0, 0, 0, 0,  32'hFFFFFFFF,  0, 0);
        // Starvation: s1 loses four cycles, boosted on the fifth
        apply(1, 1,  32'h101,       1, 7,  32'h77,        1, 0, 0, 0,  32'hFFFFFFFF,  0, 0);
        apply(1, 2,  32'h102,       1, 7,  32'h77,        1, 0, 1, 1,  32'h101,       0, 0);
        apply(1, 3,  32'h103,       1, 7,  32'h77,        1, 0, 1, 2,  32'h102,       0, 0);
        apply(1, 4,  32'h104,       1, 7,  32'h77,        1, 0, 1, 3,  32'h103,       0, 0);
        apply(1, 5,  32'h105,       1, 7,  32'h77,        0, 1, 1, 4,  32'h104,       0, 1);
        apply(1, 5,  32'h105,       0, 0,  32'h0,         1, 0, 1, 7,  32'h77,        1, 0);
        apply(0, 0,  32'h0,         0, 0,  32'h0,         0, 0, 1, 5,  32'h105,       0, 0);
        // Alternating, non-overlapping valids
        apply(1, 10, 32'hA,         0, 0,  32'h0,         1, 0, 0, 5,  32'h105,       0, 0);
        apply(0, 0,  32'h0,         1, 11, 32'hB,         0, 1, 1, 10, 32'hA,         0, 0);
        apply(1, 12, 32'hC,         0, 0,  32'h0,         1, 0, 1, 11, 32'hB,         1, 0);
        apply(0, 0,  32'h0,         1, 13, 32'hD,         0, 1, 1, 12, 32'hC,         0, 0);
        apply(0, 0,  32'h0,         0, 0,  32'h0,         0, 0, 1, 13, 32'hD,         1, 0);
        // Reach BOOST, then s1 withdraws; counter must restart from zero
        apply(1, 20, 32'h20,        1, 9,  32'h9,         1, 0, 0, 13, 32'hD,         1, 0);
        apply(1, 21, 32'h21,        1, 9,  32'h9,         1, 0, 1, 20, 32'h20,        0, 0);
        apply(1, 22, 32'h22,        1, 9,  32'h9,         1, 0, 1, 21, 32'h21,        0, 0);
        apply(1, 23, 32'h23,        1, 9,  32'h9,         1, 0, 1, 22, 32'h22,        0, 0);
        apply(1, 24, 32'h24,        0, 0,  32'h0,         1, 0, 1, 23, 32'h23,        0, 1);
        apply(1, 25, 32'h25,        1, 9,  32'h9,         1, 0, 1, 24, 32'h24,        0, 0);
        apply(1, 26, 32'h26,        1, 9,  32'h9,         1, 0, 1, 25, 32'h25,        0, 0);
        apply(1, 27, 32'h27,        1, 9,  32'h9,         1, 0, 1, 26, 32'h26,        0, 0);
        apply(1, 28, 32'h28,        1, 9,  32'h9,         1, 0, 1, 27, 32'h27,        0, 0);
        apply(1, 29, 32'h29,        1, 9,  32'h9,         0, 1, 1, 28, 32'h28,        0, 1);
        apply(0, 0,  32'h0,         0, 0,  32'h0,         0, 0, 1, 9,  32'h9,         1, 0);
        apply(0, 0,  32'h0,         0, 0,  32'h0,         0, 0, 0, 9,  32'h9,         1, 0);

        for (int i = 0; i < 8 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain_timeout: %0d expectations left, want 0", exp_q.size());
        end
        @(posedge clk); #1;
        chk("rf_x0", rf[0], 32'd0);
        chk("rf_x31", rf[31], 32'hDEADBEEF);
        chk("rf_x9", rf[9], 32'h9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
